green_centroid: RTL and testbench

//  Per-frame tracker for the green-object mask from the detectorVerde stage. Consumes the
//  per-pixel verde flag with camera timing (VSYNC/HREF/e_pix) in the PCLK domain; counts green

---
 rtl/green_centroid.sv | 190 +++++++++++++++++++
 tb/tb_green_centroid.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/green_centroid.sv
// Per-frame green-object tracker: counts mask pixels, accumulates coordinates and bounding box,
// then runs two 28-step restoring dividers after each VSYNC rising edge to produce the centroid.
module green_centroid #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic        PCLK,
    input  logic        rst,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic        e_pix,
    input  logic        verde,
    output logic        obj_valid,
    output logic        obj_found,
    output logic [9:0]  cx,
    output logic [9:0]  cy,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic [18:0] pix_count
);

    typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

    state_t      state_q, state_d;
    logic        div_en, load_out;
    logic [4:0]  step_q;

    logic        vsync_q, href_q;
    logic [9:0]  x_q, y_q;
    logic [18:0] cnt_q;
    logic [27:0] sumx_q, sumy_q;
    logic [9:0]  xmin_q, xmax_q, ymin_q, ymax_q;

    logic [18:0] s_cnt_q, divisor_q;
    logic        s_found_q;
    logic [9:0]  s_xmin_q, s_xmax_q, s_ymin_q, s_ymax_q;
    logic [27:0] numx_q, numy_q, numx_d, numy_d;
    logic [19:0] remx_q, remy_q, remx_d, remy_d;

    logic frame_end, green, found_now;

    assign frame_end = VSYNC & ~vsync_q;
    assign green     = e_pix & HREF & ~VSYNC & verde;
    assign found_now = (cnt_q >= 19'(MIN_PIXELS));

    // One restoring step: returns {remainder, numerator shifted with the new quotient bit in the LSB}.
    function automatic logic [47:0] div_step(input logic [19:0] rem, input logic [27:0] num,
                                             input logic [18:0] d);
        logic [19:0] sh;
        sh = {rem[18:0], num[27]};
        if (sh >= {1'b0, d})
            div_step = {sh - {1'b0, d}, num[26:0], 1'b1};
        else
            div_step = {sh, num[26:0], 1'b0};
    endfunction

    always_comb begin
        {remx_d, numx_d} = div_step(remx_q, numx_q, divisor_q);
        {remy_d, numy_d} = div_step(remy_q, numy_q, divisor_q);
    end

    always_comb begin
        state_d  = state_q;
        div_en   = 1'b0;
        load_out = 1'b0;
        case (state_q)
            ACCUM:  ;
            DIVIDE: begin
                div_en = 1'b1;
                if (step_q == 5'd0) state_d = DONE;
            end
            DONE: begin
                load_out = 1'b1;
                state_d  = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        // A new frame edge always wins: snapshot again and restart the division.
        if (frame_end) begin
            state_d = DIVIDE;
            div_en  = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_ff @(posedge PCLK) begin
        if (rst) begin
            vsync_q   <= 1'b1;
            href_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            sumx_q    <= '0;
            sumy_q    <= '0;
            xmin_q    <= 10'h3FF;
            xmax_q    <= '0;
            ymin_q    <= 10'h3FF;
            ymax_q    <= '0;
            step_q    <= '0;
            s_cnt_q   <= '0;
            s_found_q <= 1'b0;
            divisor_q <= 19'd1;
            s_xmin_q  <= '0;
            s_xmax_q  <= '0;
            s_ymin_q  <= '0;
            s_ymax_q  <= '0;
            numx_q    <= '0;
            numy_q    <= '0;
            remx_q    <= '0;
            remy_q    <= '0;
            obj_valid <= 1'b0;
            obj_found <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            pix_count <= '0;
        end else begin
            vsync_q <= VSYNC;
            href_q  <= HREF;

            if (!HREF)                                  x_q <= '0;
            else if (e_pix && x_q != 10'(H_RES - 1))    x_q <= x_q + 10'd1;

            if (VSYNC)                                             y_q <= '0;
            else if (href_q && !HREF && y_q != 10'(V_RES - 1))     y_q <= y_q + 10'd1;

            if (frame_end) begin
                s_cnt_q   <= cnt_q;
                s_found_q <= found_now;
                divisor_q <= found_now ? cnt_q : 19'd1;
                s_xmin_q  <= xmin_q;
                s_xmax_q  <= xmax_q;
                s_ymin_q  <= ymin_q;
                s_ymax_q  <= ymax_q;
                numx_q    <= sumx_q;
                numy_q    <= sumy_q;
                remx_q    <= '0;
                remy_q    <= '0;
                step_q    <= 5'd27;
                cnt_q     <= '0;
                sumx_q    <= '0;
                sumy_q    <= '0;
                xmin_q    <= 10'h3FF;
                xmax_q    <= '0;
                ymin_q    <= 10'h3FF;
                ymax_q    <= '0;
            end else begin
                if (green) begin
                    cnt_q  <= cnt_q + 19'd1;
                    sumx_q <= sumx_q + {18'd0, x_q};
                    sumy_q <= sumy_q + {18'd0, y_q};
                    if (x_q < xmin_q) xmin_q <= x_q;
                    if (x_q > xmax_q) xmax_q <= x_q;
                    if (y_q < ymin_q) ymin_q <= y_q;
                    if (y_q > ymax_q) ymax_q <= y_q;
                end
                if (div_en) begin
                    numx_q <= numx_d;
                    numy_q <= numy_d;
                    remx_q <= remx_d;
                    remy_q <= remy_d;
                    step_q <= step_q - 5'd1;
                end
            end

            obj_valid <= load_out;
            if (load_out) begin
                obj_found <= s_found_q;
                pix_count <= s_cnt_q;
                cx        <= s_found_q ? numx_q[9:0] : 10'd0;
                cy        <= s_found_q ? numy_q[9:0] : 10'd0;
                x_min     <= s_found_q ? s_xmin_q : 10'd0;
                x_max     <= s_found_q ? s_xmax_q : 10'd0;
                y_min     <= s_found_q ? s_ymin_q : 10'd0;
                y_max     <= s_found_q ? s_ymax_q : 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_green_centroid.sv
// Randomized bench for green_centroid: pixel-level stimulus with a coordinate-list reference
// model, frame-result latency checks, abort-on-early-VSYNC and mid-divide reset.
module tb_green_centroid;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int MINP = 64;

    logic        PCLK = 1'b0;
    logic        rst, VSYNC, HREF, e_pix, verde;
    logic        obj_valid, obj_found;
    logic [9:0]  cx, cy, x_min, x_max, y_min, y_max;
    logic [18:0] pix_count;

    green_centroid #(.H_RES(H), .V_RES(V), .MIN_PIXELS(MINP)) dut (
        .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .e_pix(e_pix), .verde(verde),
        .obj_valid(obj_valid), .obj_found(obj_found), .cx(cx), .cy(cy),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .pix_count(pix_count)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: the set of green pixel coordinates of the current frame, reduced with plain arithmetic.
    int     px[$];
    int     py[$];
    int     e_found, e_cx, e_cy, e_xmin, e_xmax, e_ymin, e_ymax, e_count;

    task automatic compute_expected();
        longint sx, sy;
        int xmn, xmx, ymn, ymx;
        sx = 0; sy = 0; xmn = H; xmx = -1; ymn = V; ymx = -1;
        foreach (px[i]) begin
            sx += px[i];
            sy += py[i];
            if (px[i] < xmn) xmn = px[i];
            if (px[i] > xmx) xmx = px[i];
            if (py[i] < ymn) ymn = py[i];
            if (py[i] > ymx) ymx = py[i];
        end
        e_count = px.size();
        if (e_count >= MINP) begin
            e_found = 1;
            e_cx = int'(sx / e_count);
            e_cy = int'(sy / e_count);
            e_xmin = xmn; e_xmax = xmx; e_ymin = ymn; e_ymax = ymx;
        end else begin
            e_found = 0; e_cx = 0; e_cy = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".found"}, 32'(obj_found), 32'(e_found));
        check({tag, ".cx"},    32'(cx),        32'(e_cx));
        check({tag, ".cy"},    32'(cy),        32'(e_cy));
        check({tag, ".xmin"},  32'(x_min),     32'(e_xmin));
        check({tag, ".xmax"},  32'(x_max),     32'(e_xmax));
        check({tag, ".ymin"},  32'(y_min),     32'(e_ymin));
        check({tag, ".ymax"},  32'(y_max),     32'(e_ymax));
        check({tag, ".count"}, 32'(pix_count), 32'(e_count));
    endtask

    // Lines below full_from are one-cycle HREF pulses with no pixels (they just advance y).
    task automatic drive_frame(input int nlines, input int full_from, input int npix,
                               input int gx0, input int gx1, input int gy0, input int gy1,
                               input int prob);
        int  xp, xc, yc;
        bit  g;
        px.delete();
        py.delete();
        VSYNC = 1'b0; HREF = 1'b0; e_pix = 1'b0;
        repeat (2) @(negedge PCLK);
        for (int l = 0; l < nlines; l++) begin
            yc = (l > V - 1) ? V - 1 : l;
            HREF = 1'b1;
            if (l < full_from) begin
                e_pix = 1'b0; verde = 1'($urandom);
                @(negedge PCLK);
            end else begin
                xp = 0;
                while (xp < npix) begin
                    if ($urandom_range(7) == 0) begin
                        e_pix = 1'b0; verde = 1'($urandom);
                    end else begin
                        xc = (xp > H - 1) ? H - 1 : xp;
                        g  = (xc >= gx0 && xc <= gx1 && yc >= gy0 && yc <= gy1) ||
                             ($urandom_range(99) < prob);
                        e_pix = 1'b1; verde = g;
                        if (g) begin px.push_back(xc); py.push_back(yc); end
                        xp++;
                    end
                    @(negedge PCLK);
                end
            end
            HREF = 1'b0; e_pix = 1'b0; verde = 1'($urandom);
            repeat (2) @(negedge PCLK);
        end
    endtask

    // Raise VSYNC; obj_valid must appear after exactly 29 further edges, once, carrying the model result.
    task automatic end_frame(input string tag);
        int seen, pulses;
        compute_expected();
        VSYNC = 1'b1;
        seen = -1; pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (obj_valid) begin
                pulses++;
                if (seen < 0) seen = k;
            end
        end
        check({tag, ".latency"}, 32'(seen), 32'd29);
        check({tag, ".pulses"},  32'(pulses), 32'd1);
        check_outputs(tag);
    endtask

    initial begin
        int gx0, gy0, pulses;
        rst = 1'b1; VSYNC = 1'b1; HREF = 1'b0; e_pix = 1'b0; verde = 1'b0;
        repeat (3) @(negedge PCLK);
        px.delete(); py.delete();
        compute_expected();
        check("reset.valid", 32'(obj_valid), 32'd0);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge PCLK);

        drive_frame(51, 50, 101, 100, 100, 50, 50, 0);
        end_frame("single_px");

        drive_frame(310, 300, 220, 200, 219, 300, 309, 0);
        end_frame("rect");

        drive_frame(5, 0, 30, 1, 0, 1, 0, 0);
        end_frame("empty");

        drive_frame(1, 0, 63, 0, 62, 0, 0, 0);
        end_frame("below_min");

        drive_frame(1, 0, 64, 0, 63, 0, 0, 0);
        end_frame("at_min");

        drive_frame(490, 470, 700, 0, H - 1, 0, V - 1, 0);
        end_frame("saturate");

        for (int r = 0; r < 4; r++) begin
            gx0 = $urandom_range(0, 60);
            gy0 = $urandom_range(0, 20);
            drive_frame($urandom_range(10, 40), $urandom_range(0, 5), $urandom_range(20, 120),
                        gx0, gx0 + $urandom_range(0, 40), gy0, gy0 + $urandom_range(0, 15),
                        $urandom_range(0, 30));
            end_frame($sformatf("rand%0d", r));
        end

        // Early second VSYNC edge: first result discarded, outputs hold, one pulse for the empty frame.
        drive_frame(20, 0, 60, 10, 50, 2, 15, 0);
        VSYNC = 1'b1;
        pulses = 0;
        repeat (8) @(negedge PCLK) if (obj_valid) pulses++;
        check("abort.hold_cx",    32'(cx),        32'(e_cx));
        check("abort.hold_count", 32'(pix_count), 32'(e_count));
        VSYNC = 1'b0;
        @(negedge PCLK) if (obj_valid) pulses++;
        check("abort.no_pulse", 32'(pulses), 32'd0);
        px.delete(); py.delete();
        end_frame("abort");

        // Reset in the middle of the division: no pulse, outputs cleared.
        drive_frame(20, 0, 80, 0, 79, 0, 19, 0);
        VSYNC = 1'b1;
        pulses = 0;
        repeat (15) @(negedge PCLK) if (obj_valid) pulses++;
        rst = 1'b1;
        @(negedge PCLK);
        rst = 1'b0;
        repeat (40) @(negedge PCLK) if (obj_valid) pulses++;
        check("midrst.no_pulse", 32'(pulses), 32'd0);
        px.delete(); py.delete();
        compute_expected();
        check_outputs("midrst");

        drive_frame(30, 0, 90, 20, 89, 5, 29, 10);
        end_frame("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
